axi_slave_wr_ctrl: RTL and testbench

//  AXI4 write-channel responder (slave side). Accepts AW requests into an internal

---
 rtl/axi_slave_wr_ctrl.sv | 157 +++++++++++++++
 tb/tb_axi_slave_wr_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_wr_ctrl.sv
// AXI4 write-channel slave: AW queue, W beat consumer driving a local memory port, one B per burst.
// Optional 4KB-boundary check enabled by defining AXI_SLV_WR_4K_CHECK_EN.
module axi_slave_wr_ctrl #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int AW_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [1:0]              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // holds its payload stable until ready, and ready never waits on valid.
  localparam int PW    = $clog2(AW_DEPTH);
  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_RESP = 2'd2} state_t;

  state_t state;

  logic [ID_WIDTH-1:0]   q_id    [AW_DEPTH];
  logic [ADDR_WIDTH-1:0] q_addr  [AW_DEPTH];
  logic [7:0]            q_len   [AW_DEPTH];
  logic [1:0]            q_burst [AW_DEPTH];

  logic [PW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic        empty, full_n, push, pop;

  logic [ID_WIDTH-1:0]   head_id, cur_id;
  logic [ADDR_WIDTH-1:0] head_addr, cur_addr;
  logic [7:0]            head_len, cur_len, cnt;
  logic [1:0]            head_burst, cur_burst;
  logic                  err, beat, last_beat, err_beat, chk4k;

  assign empty      = (wr_ptr == rd_ptr);
  assign push       = awvalid && awready;
  assign pop        = (state == S_IDLE) && !empty;
  assign wr_ptr_n   = wr_ptr + (PW+1)'(push);
  assign rd_ptr_n   = rd_ptr + (PW+1)'(pop);
  assign full_n     = (wr_ptr_n[PW-1:0] == rd_ptr_n[PW-1:0]) && (wr_ptr_n[PW] != rd_ptr_n[PW]);

  assign head_id    = q_id[rd_ptr[PW-1:0]];
  assign head_addr  = q_addr[rd_ptr[PW-1:0]];
  assign head_len   = q_len[rd_ptr[PW-1:0]];
  assign head_burst = q_burst[rd_ptr[PW-1:0]];

`ifdef AXI_SLV_WR_4K_CHECK_EN
  // Burst end offset measured from the start of the 4KB page it begins in.
  assign chk4k = (head_burst == 2'b01) &&
                 (({20'd0, head_addr[11:0]} + ({24'd0, head_len} + 32'd1) * 32'(BYTES)) > 32'd4096);
`else
  assign chk4k = 1'b0;
`endif

  assign beat      = wvalid && wready;
  assign last_beat = (cnt == cur_len);
  assign err_beat  = err || (wlast != last_beat);

  assign mem_we    = beat && !err;
  assign mem_addr  = cur_addr;
  assign mem_wdata = wdata;
  assign mem_wstrb = wstrb;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (push) begin
      q_id[wr_ptr[PW-1:0]]    <= awid;
      q_addr[wr_ptr[PW-1:0]]  <= awaddr;
      q_len[wr_ptr[PW-1:0]]   <= awlen;
      q_burst[wr_ptr[PW-1:0]] <= awburst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bid       <= '0;
      bresp     <= 2'b00;
      cur_id    <= '0;
      cur_addr  <= '0;
      cur_len   <= '0;
      cur_burst <= 2'b00;
      cnt       <= '0;
      err       <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      awready <= !full_n;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            state     <= S_DATA;
            wready    <= 1'b1;
            cur_id    <= head_id;
            cur_addr  <= head_addr;
            cur_len   <= head_len;
            cur_burst <= head_burst;
            cnt       <= '0;
            err       <= head_burst[1] || chk4k;
          end
        end
        S_DATA: begin
          if (beat) begin
            cnt <= cnt + 8'd1;
            err <= err_beat;
            if (cur_burst == 2'b01) cur_addr <= cur_addr + ADDR_WIDTH'(BYTES);
            // The burst length comes from AWLEN; WLAST only flags errors.
            if (last_beat) begin
              state  <= S_RESP;
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= cur_id;
              bresp  <= err_beat ? 2'b10 : 2'b00;
            end
          end
        end
        S_RESP: begin
          if (bready) begin
            state  <= S_IDLE;
            bvalid <= 1'b0;
            bid    <= '0;
            bresp  <= 2'b00;
            err    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_wr_ctrl.sv
// Directed bench for axi_slave_wr_ctrl with a burst-level reference model and per-cycle compare.
module tb_axi_slave_wr_ctrl;

  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;

  logic          clk, rst_n;
  logic [IDW-1:0] awid;
  logic [AW-1:0]  awaddr;
  logic [7:0]     awlen;
  logic [1:0]     awburst;
  logic           awvalid, awready;
  logic [DW-1:0]  wdata;
  logic [SW-1:0]  wstrb;
  logic           wlast, wvalid, wready;
  logic [IDW-1:0] bid;
  logic [1:0]     bresp;
  logic           bvalid, bready;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [SW-1:0]  mem_wstrb;
  logic [1:0]     dbg_state;

  axi_slave_wr_ctrl #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AW_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- model state / scoreboard ----------------
  typedef struct {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [7:0]     len;
    logic [1:0]     burst;
  } aw_t;

  aw_t              aw_q[$];
  logic [AW+DW+SW-1:0] exp_wr_q[$];
  logic [IDW+1:0]   exp_b_q[$];

  logic [AW-1:0]  obs_addr_q[$];
  int             wr_count = 0;
  int             b_count  = 0;
  logic [IDW-1:0] last_bid;
  logic [1:0]     last_bresp;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every write and every B handshake against the model queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        wr_count++;
        obs_addr_q.push_back(mem_addr);
        if (exp_wr_q.size() == 0) check("unexpected_mem_we", 96'(mem_we), 96'd0);
        else check("mem_write", 96'({mem_addr, mem_wdata, mem_wstrb}), 96'(exp_wr_q.pop_front()));
      end
      if (bvalid) check("wready_in_resp", 96'(wready), 96'd0);
      if (bvalid && bready) begin
        b_count++;
        last_bid   = bid;
        last_bresp = bresp;
        if (exp_b_q.size() == 0) check("unexpected_bvalid", 96'(bvalid), 96'd0);
        else check("b_resp", 96'({bid, bresp}), 96'(exp_b_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_aw(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                       input logic [7:0] len, input logic [1:0] burst);
    aw_t a;
    int  t;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!awready && t < 200);
    if (!awready) check("aw_timeout", 96'(awready), 96'd1);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    a.id = id; a.addr = addr; a.len = len; a.burst = burst;
    aw_q.push_back(a);
  endtask

  task automatic w_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
    int t;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!wready && t < 200);
    if (!wready) check("w_timeout", 96'(wready), 96'd1);
    @(posedge clk);
    #1;
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  // Sends nsend beats of the oldest outstanding AW; wlast is raised on beat last_idx.
  task automatic do_w(input int nsend, input int last_idx);
    aw_t           a;
    logic          e;
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          l;
    if (aw_q.size() == 0) begin
      check("model_aw_empty", 96'(aw_q.size()), 96'd1);
      return;
    end
    a    = aw_q.pop_front();
    e    = (a.burst == 2'b10) || (a.burst == 2'b11);
`ifdef AXI_SLV_WR_4K_CHECK_EN
    if (a.burst == 2'b01 && (int'(a.addr[11:0]) + (int'(a.len) + 1) * SW) > 4096) e = 1'b1;
`endif
    addr = a.addr;
    for (int i = 0; i < nsend; i++) begin
      d = $urandom;
      s = SW'($urandom_range(0, (1 << SW) - 1));
      l = (i == last_idx);
      if (!e) exp_wr_q.push_back({addr, d, s});
      if (l != (i == int'(a.len))) e = 1'b1;
      w_beat(d, s, l);
      if (a.burst == 2'b01) addr = addr + AW'(SW);
    end
    if (nsend == int'(a.len) + 1) exp_b_q.push_back({a.id, e ? 2'b10 : 2'b00});
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  int w0;

  initial begin
    rst_n = 1'b0; awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awburst = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 96'({awready, wready, bvalid, mem_we, bid, bresp}), 96'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("awready_after_reset", 96'(awready), 96'd1);

    // T1: INCR burst, first beat on the second edge after the AW handshake
    obs_addr_q.delete();
    do_aw(4'd3, 32'h100, 8'd3, 2'b01);
    check("wready_before_data", 96'(wready), 96'd0);
    @(posedge clk);
    #1;
    check("wready_in_data", 96'(wready), 96'd1);
    do_w(4, 3);
    settle();
    check("t1_write_count", 96'(obs_addr_q.size()), 96'd4);
    if (obs_addr_q.size() == 4) begin
      check("t1_addr0", 96'(obs_addr_q[0]), 96'h100);
      check("t1_addr1", 96'(obs_addr_q[1]), 96'h104);
      check("t1_addr2", 96'(obs_addr_q[2]), 96'h108);
      check("t1_addr3", 96'(obs_addr_q[3]), 96'h10C);
    end
    check("t1_b", 96'({last_bid, last_bresp}), 96'({4'd3, 2'b00}));

    // T2: five AWs with W held off; head is popped into DATA so four more fill the queue
    w0 = b_count;
    for (int k = 0; k < 5; k++) do_aw(IDW'(k + 1), 32'h1000 + 32'(k * 'h100), 8'd1, 2'b01);
    check("t2_full_awready", 96'(awready), 96'd0);
    repeat (4) @(posedge clk);
    #1;
    check("t2_full_held", 96'(awready), 96'd0);
    for (int k = 0; k < 5; k++) do_w(2, 1);
    settle();
    check("t2_b_count", 96'(b_count - w0), 96'd5);
    check("t2_last_bid", 96'(last_bid), 96'd5);

    // T3: wlast on beat 2 of 4
    w0 = wr_count;
    do_aw(4'd4, 32'h300, 8'd3, 2'b01);
    do_w(4, 1);
    settle();
    check("t3_writes", 96'(wr_count - w0), 96'd2);
    check("t3_bresp", 96'(last_bresp), 96'd2);

    // T4: WRAP is unsupported
    w0 = wr_count;
    do_aw(4'd5, 32'h400, 8'd1, 2'b10);
    do_w(2, 1);
    settle();
    check("t4_writes", 96'(wr_count - w0), 96'd0);
    check("t4_bresp", 96'(last_bresp), 96'd2);

    // FIXED burst holds the address; INCR wraps around the address space
    obs_addr_q.delete();
    do_aw(4'd9, 32'h40, 8'd2, 2'b00);
    do_w(3, 2);
    settle();
    check("fixed_addr_last", 96'(obs_addr_q.size() == 3 ? obs_addr_q[2] : 32'hDEAD), 96'h40);
    do_aw(4'd10, 32'hFFFF_FFFC, 8'd1, 2'b01);
    do_w(2, 1);
    do_aw(4'd2, 32'h0, 8'd0, 2'b11);
    do_w(1, 0);
    settle();

    // T5: B stall keeps response stable with wready low
    bready = 1'b0;
    do_aw(4'd11, 32'h200, 8'd0, 2'b01);
    do_w(1, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t5_stall", 96'({bvalid, wready, bid, bresp}), 96'({1'b1, 1'b0, 4'd11, 2'b00}));
    end
    bready = 1'b1;
    settle();
    check("t5_released", 96'(bvalid), 96'd0);

    // Reset mid-burst with two more AWs queued
    do_aw(4'd6, 32'h500, 8'd3, 2'b01);
    do_aw(4'd7, 32'h600, 8'd1, 2'b01);
    do_aw(4'd8, 32'h700, 8'd1, 2'b01);
    do_w(2, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midburst_reset_outputs", 96'({awready, wready, bvalid, mem_we, bid, bresp}), 96'd0);
    aw_q.delete();
    exp_b_q.delete();
    check("midburst_pending_writes", 96'(exp_wr_q.size()), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("flushed_queue", 96'({awready, wready, bvalid}), 96'({1'b1, 1'b0, 1'b0}));

    // T6: burst crossing a 4KB page
    w0 = wr_count;
    obs_addr_q.delete();
    do_aw(4'd12, 32'hFF8, 8'd3, 2'b01);
    do_w(4, 3);
    settle();
`ifdef AXI_SLV_WR_4K_CHECK_EN
    check("t6_writes", 96'(wr_count - w0), 96'd0);
    check("t6_bresp", 96'(last_bresp), 96'd2);
`else
    check("t6_writes", 96'(wr_count - w0), 96'd4);
    check("t6_bresp", 96'(last_bresp), 96'd0);
    check("t6_addr2", 96'(obs_addr_q.size() == 4 ? obs_addr_q[2] : 32'hDEAD), 96'h1000);
`endif

    check("end_exp_wr_empty", 96'(exp_wr_q.size()), 96'd0);
    check("end_exp_b_empty", 96'(exp_b_q.size()), 96'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
